updown_counter_ranged: RTL and testbench

Parametrised, range-bounded up/down counter with programmable step, runtime limits, parallel load and four count modes: wrap, saturate, ping-pong and hold. It generalises the team's fixed 4-bit up/down counter for timer, PWM-ramp and address-sweep uses across course lab designs. A registered terminal-count pulse lets downstream logic chain or interrupt on limit events.

---
 rtl/updown_counter_pkg.sv | 19 +
 rtl/counter_next_calc.sv | 135 +++++++++++++
 rtl/updown_counter_ranged.sv | 107 ++++++++++
 tb/tb_updown_counter_ranged.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// Shared types for the ranged up/down counter: count modes and direction encoding.
package updown_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // WRAP and SATURATE take their direction from the up input; other modes keep dir.
    function automatic logic mode_uses_up(input mode_t m);
        return (m == MODE_WRAP) || (m == MODE_SAT);
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-state for one enabled step of the ranged counter.
// All limit arithmetic is done one bit wider than the counter so nothing aliases.
module counter_next_calc
    import updown_counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic              dir,
    input  mode_t             mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  count_next,
    output logic              dir_next,
    output logic              tc_next,
    output logic              wrap_err
);

    localparam int XW = WIDTH + 1;

    logic [XW-1:0]    cnt_x;
    logic [XW-1:0]    lo_x;
    logic [XW-1:0]    hi_x;
    logic [XW-1:0]    step_x;
    logic [XW-1:0]    span_x;
    logic [XW-1:0]    sum_x;
    logic [XW-1:0]    lo_step_x;
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] up_wrap_w;
    logic [WIDTH-1:0] dn_wrap_w;

    assign cnt_x     = {1'b0, count};
    assign lo_x      = {1'b0, lo};
    assign hi_x      = {1'b0, hi};
    assign step_x    = {{(XW - STEP_W){1'b0}}, step};
    assign span_x    = hi_x - lo_x + XW'(1);
    assign sum_x     = cnt_x + step_x;
    assign lo_step_x = lo_x + step_x;

    assign sum_w     = WIDTH'(sum_x);
    assign diff_w    = WIDTH'(cnt_x - step_x);
    // Overshoot past one limit re-enters from the opposite limit.
    assign up_wrap_w = WIDTH'(lo_x + (sum_x - hi_x - XW'(1)));
    assign dn_wrap_w = WIDTH'(hi_x - (lo_step_x - cnt_x - XW'(1)));

    always_comb begin
        count_next = count;
        dir_next   = dir;
        tc_next    = 1'b0;
        wrap_err   = 1'b0;

        if (mode == MODE_HOLD) begin
            count_next = count;
        end else if (cnt_x > hi_x) begin
            count_next = hi;
        end else if (cnt_x < lo_x) begin
            count_next = lo;
        end else if (step == '0) begin
            count_next = count;
        end else begin
            case (mode)
                MODE_WRAP: begin
                    if (dir == DIR_UP) begin
                        if (sum_x <= hi_x) begin
                            count_next = sum_w;
                        end else begin
                            tc_next = 1'b1;
                            if (step_x > span_x) begin
                                count_next = lo;
                                wrap_err   = 1'b1;
                            end else begin
                                count_next = up_wrap_w;
                            end
                        end
                    end else begin
                        if (cnt_x >= lo_step_x) begin
                            count_next = diff_w;
                        end else begin
                            tc_next = 1'b1;
                            if (step_x > span_x) begin
                                count_next = hi;
                                wrap_err   = 1'b1;
                            end else begin
                                count_next = dn_wrap_w;
                            end
                        end
                    end
                end
                MODE_SAT: begin
                    if (dir == DIR_UP) begin
                        if (sum_x >= hi_x) begin
                            count_next = hi;
                            tc_next    = (count != hi);
                        end else begin
                            count_next = sum_w;
                        end
                    end else begin
                        if (cnt_x <= lo_step_x) begin
                            count_next = lo;
                            tc_next    = (count != lo);
                        end else begin
                            count_next = diff_w;
                        end
                    end
                end
                MODE_PINGPONG: begin
                    if (dir == DIR_UP) begin
                        if (sum_x >= hi_x) begin
                            count_next = hi;
                            dir_next   = DIR_DOWN;
                            tc_next    = 1'b1;
                        end else begin
                            count_next = sum_w;
                        end
                    end else begin
                        if (cnt_x <= lo_step_x) begin
                            count_next = lo;
                            dir_next   = DIR_UP;
                            tc_next    = 1'b1;
                        end else begin
                            count_next = diff_w;
                        end
                    end
                end
                default: begin
                    count_next = count;
                end
            endcase
        end
    end

endmodule

// File: rtl/updown_counter_ranged.sv
// Range-bounded up/down counter: owns the state registers, edge priority,
// load clamping and limit sanity check; step arithmetic lives in counter_next_calc.
module updown_counter_ranged
    import updown_counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              dir,
    output logic              tc,
    output logic              err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;

    mode_t            mode_s;
    logic             cfg_err;
    logic             calc_dir;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] calc_count;
    logic             calc_dir_next;
    logic             calc_tc;
    logic             calc_wrap_err;

    assign mode_s   = mode_t'(mode);
    assign cfg_err  = (lo > hi);
    assign calc_dir = mode_uses_up(mode_s) ? up : dir_q;

    always_comb begin
        load_clamped = load_val;
        if (load_val > hi) begin
            load_clamped = hi;
        end else if (load_val < lo) begin
            load_clamped = lo;
        end
    end

    counter_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .count      (count_q),
        .dir        (calc_dir),
        .mode       (mode_s),
        .step       (step),
        .lo         (lo),
        .hi         (hi),
        .count_next (calc_count),
        .dir_next   (calc_dir_next),
        .tc_next    (calc_tc),
        .wrap_err   (calc_wrap_err)
    );

    // err tracks the limit check every edge; an enabled WRAP overshoot can pulse it.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        err_d   = cfg_err;

        if (load) begin
            count_d = cfg_err ? load_val : load_clamped;
            dir_d   = up;
        end else if (cfg_err) begin
            count_d = count_q;
        end else if (en) begin
            count_d = calc_count;
            dir_d   = calc_dir_next;
            tc_d    = calc_tc;
            err_d   = calc_wrap_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            dir_q   <= DIR_UP;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign tc    = tc_q;
    assign err   = err_q;

endmodule

// File: tb/tb_updown_counter_ranged.sv
// Self-checking bench for updown_counter_ranged: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_updown_counter_ranged;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic              clk;
    logic              reset;
    logic              en;
    logic [1:0]        mode;
    logic              up;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  count;
    logic              dir;
    logic              tc;
    logic              err;

    int errors = 0;
    int checks = 0;

    updown_counter_ranged #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .up       (up),
        .step     (step),
        .lo       (lo),
        .hi       (hi),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .dir      (dir),
        .tc       (tc),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int val, input logic up_v);
        en       = 1'b0;
        load     = 1'b1;
        load_val = WIDTH'(val);
        up       = up_v;
        tick();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'd77;
        mode = 2'd0; up = 1'b0; step = 4'd3; lo = 8'd0; hi = 8'd15;
        tick();
        tick();
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir got=%0b want=1", dir); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%0b want=0", tc); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", err); end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_wrap_up();
        int exp_c;
        lo = 8'd0; hi = 8'd15; step = 4'd1; up = 1'b1; mode = 2'd0; en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_c = i % 16;
            checks++; if (int'(count) !== exp_c) begin errors++; $display("FAIL wrap_up_count[%0d] got=%0d want=%0d", i, count, exp_c); end
            checks++; if (tc !== (i == 16)) begin errors++; $display("FAIL wrap_up_tc[%0d] got=%0b want=%0b", i, tc, (i == 16)); end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_remainder();
        lo = 8'd10; hi = 8'd20; mode = 2'd0; step = 4'd4;
        do_load(18, 1'b1);
        checks++; if (count !== 8'd18) begin errors++; $display("FAIL wrap_rem_load got=%0d want=18", count); end
        en = 1'b1; tick(); en = 1'b0;
        checks++; if (count !== 8'd11) begin errors++; $display("FAIL wrap_rem_up_count got=%0d want=11", count); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL wrap_rem_up_tc got=%0b want=1", tc); end
        do_load(12, 1'b0);
        en = 1'b1; tick(); en = 1'b0;
        checks++; if (count !== 8'd19) begin errors++; $display("FAIL wrap_rem_dn_count got=%0d want=19", count); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL wrap_rem_dn_tc got=%0b want=1", tc); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL wrap_rem_dn_dir got=%0b want=0", dir); end
    endtask

    task automatic test_saturate();
        int exp_c[4] = '{6, 5, 5, 5};
        bit exp_t[4] = '{0, 1, 0, 0};
        lo = 8'd5; hi = 8'd100; step = 4'd3; mode = 2'd1;
        do_load(9, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (int'(count) !== exp_c[i]) begin errors++; $display("FAIL sat_count[%0d] got=%0d want=%0d", i, count, exp_c[i]); end
            checks++; if (tc !== exp_t[i]) begin errors++; $display("FAIL sat_tc[%0d] got=%0b want=%0b", i, tc, exp_t[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_pingpong();
        int exp_c[5] = '{5, 8, 5, 2, 5};
        bit exp_t[5] = '{0, 1, 0, 1, 0};
        bit exp_d[5] = '{1, 0, 0, 1, 1};
        lo = 8'd2; hi = 8'd8; step = 4'd3; mode = 2'd0;
        do_load(2, 1'b1);
        mode = 2'd2; up = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (int'(count) !== exp_c[i]) begin errors++; $display("FAIL pp_count[%0d] got=%0d want=%0d", i, count, exp_c[i]); end
            checks++; if (tc !== exp_t[i]) begin errors++; $display("FAIL pp_tc[%0d] got=%0b want=%0b", i, tc, exp_t[i]); end
            checks++; if (dir !== exp_d[i]) begin errors++; $display("FAIL pp_dir[%0d] got=%0b want=%0b", i, dir, exp_d[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        lo = 8'd0; hi = 8'd100; mode = 2'd0; step = 4'd1; up = 1'b1;
        en = 1'b1; load = 1'b1; load_val = 8'd200;
        tick();
        checks++; if (count !== 8'd100) begin errors++; $display("FAIL load_clamp got=%0d want=100", count); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL load_tc got=%0b want=0", tc); end
        reset = 1'b1; load_val = 8'd50;
        tick();
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_over_load got=%0d want=0", count); end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_errors();
        lo = 8'd30; hi = 8'd20; mode = 2'd0; step = 4'd1; up = 1'b1; en = 1'b1;
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL cfg_err_set got=%0b want=1", err); end
        tick();
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL cfg_err_freeze got=%0d want=0", count); end
        en = 1'b0; load = 1'b1; load_val = 8'd250;
        tick();
        load = 1'b0;
        checks++; if (count !== 8'd250) begin errors++; $display("FAIL cfg_err_load got=%0d want=250", count); end
        lo = 8'd0;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear got=%0b want=0", err); end

        lo = 8'd0; hi = 8'd3; step = 4'd9;
        do_load(3, 1'b1);
        en = 1'b1; tick(); en = 1'b0;
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL wrap_big_count got=%0d want=0", count); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wrap_big_err got=%0b want=1", err); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_big_err_pulse got=%0b want=0", err); end
    endtask

    task automatic test_random();
        int  m_count;
        bit  m_dir;
        int  c, l, h, s, span, md;
        bit  d, e_tc, e_err;
        reset = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        reset = 1'b0;
        m_count = 0; m_dir = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                lo = WIDTH'($urandom_range(0, 255));
                hi = WIDTH'($urandom_range(0, 255));
            end else if ($urandom_range(0, 7) == 0) begin
                lo = WIDTH'($urandom_range(0, 120));
                hi = WIDTH'($urandom_range(130, 255));
            end
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            up       = 1'($urandom_range(0, 1));
            step     = STEP_W'($urandom_range(0, 15));
            en       = ($urandom_range(0, 9) < 8);
            load     = ($urandom_range(0, 19) == 0);
            load_val = WIDTH'($urandom_range(0, 255));

            l = int'(lo); h = int'(hi); s = int'(step); md = int'(mode);
            c = m_count; e_tc = 1'b0; e_err = (l > h);
            if (load) begin
                c = int'(load_val);
                if (l <= h) c = (c > h) ? h : ((c < l) ? l : c);
                m_dir = up;
            end else if (l <= h && en && md != 3) begin
                span = h - l + 1;
                d = (md < 2) ? up : m_dir;
                if (c > h) c = h;
                else if (c < l) c = l;
                else if (s != 0) begin
                    if (md == 0 && d) begin
                        if (c + s > h) begin
                            e_tc = 1'b1;
                            if (s > span) begin c = l; e_err = 1'b1; end
                            else c = (c - l + s) % span + l;
                        end else c = c + s;
                    end else if (md == 0) begin
                        if (c - s < l) begin
                            e_tc = 1'b1;
                            if (s > span) begin c = h; e_err = 1'b1; end
                            else c = ((c - l - s) % span + span) % span + l;
                        end else c = c - s;
                    end else if (md == 1 && d) begin
                        e_tc = (c + s >= h) && (c != h);
                        c = (c + s >= h) ? h : c + s;
                    end else if (md == 1) begin
                        e_tc = (c - s <= l) && (c != l);
                        c = (c - s <= l) ? l : c - s;
                    end else if (d) begin
                        if (c + s >= h) begin c = h; d = 1'b0; e_tc = 1'b1; end
                        else c = c + s;
                    end else begin
                        if (c - s <= l) begin c = l; d = 1'b1; e_tc = 1'b1; end
                        else c = c - s;
                    end
                end
                m_dir = d;
            end
            m_count = c;

            tick();
            checks++; if (int'(count) !== m_count) begin errors++; $display("FAIL rand_count[%0d] got=%0d want=%0d", n, count, m_count); end
            checks++; if (dir !== m_dir) begin errors++; $display("FAIL rand_dir[%0d] got=%0b want=%0b", n, dir, m_dir); end
            checks++; if (tc !== e_tc) begin errors++; $display("FAIL rand_tc[%0d] got=%0b want=%0b", n, tc, e_tc); end
            checks++; if (err !== e_err) begin errors++; $display("FAIL rand_err[%0d] got=%0b want=%0b", n, err, e_err); end
        end
        en = 1'b0; load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'd0; up = 1'b1; step = '0;
        lo = '0; hi = '0; load = 1'b0; load_val = '0;
        test_reset();
        test_wrap_up();
        test_wrap_remainder();
        test_saturate();
        test_pingpong();
        test_load_priority();
        test_errors();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
